// File: rtl/fir_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fir_ctrl_pkg                                                    |
// | Brief    : Shared sizing constants and sequencer state encoding.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package fir_ctrl_pkg;

    localparam int NUM_TAPS   = 33;
    localparam int BANK_DEPTH = 10;
    localparam int NUM_BANKS  = 4;
    localparam int DW         = 16;
    localparam int IDX_W      = 6;
    localparam int LADDR_W    = 4;
    localparam int BANK_W     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } seqState_t;

endpackage
`default_nettype wire

// File: rtl/fir_bank_addr_map.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fir_bank_addr_map                                               |
// | Brief    : Global tap index -> one-hot bank select, bank-local address.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fir_bank_addr_map
    import fir_ctrl_pkg::*;
(
    input  logic [IDX_W-1:0]     i_idx,
    output logic [NUM_BANKS-1:0] o_bankSel,
    output logic [LADDR_W-1:0]   o_localAddr,
    output logic                 o_rangeOk
);

    // Range compare per bank keeps the map free of a real divider.
    always_comb begin
        o_rangeOk   = (i_idx < IDX_W'(NUM_TAPS));
        o_bankSel   = '0;
        o_localAddr = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (o_rangeOk && (i_idx >= IDX_W'(b * BANK_DEPTH)) &&
                (i_idx < IDX_W'((b + 1) * BANK_DEPTH))) begin
                o_bankSel[b] = 1'b1;
                o_localAddr  = LADDR_W'(i_idx - IDX_W'(b * BANK_DEPTH));
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_coeff_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fir_coeff_sequencer                                             |
// | Brief    : Coefficient write/load sequencer and sample strobe pipeline.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fir_coeff_sequencer
    import fir_ctrl_pkg::*;
(
    input  logic                    iClk_12M,
    input  logic                    iRsn,
    input  logic                    iEnSample_300k,
    input  logic                    iCoeffUpdateFlag,
    input  logic                    iCsnRam,
    input  logic                    iWrnRam,
    input  logic [5:0]              iAddrRam,
    input  logic [DW-1:0]           iWrDtRam,
    input  logic [5:0]              iNumOfCoeff,
    input  logic [NUM_BANKS*DW-1:0] iRdDtRam,
    output logic [NUM_BANKS-1:0]    oCsnRam,
    output logic [NUM_BANKS-1:0]    oWrnRam,
    output logic [LADDR_W-1:0]      oAddrRam,
    output logic [DW-1:0]           oWrDtRam,
    output logic                    oCoeffVld,
    output logic [5:0]              oCoeffIdx,
    output logic [DW-1:0]           oCoeffData,
    output logic                    oEnMul,
    output logic                    oEnAdd,
    output logic                    oEnAcc,
    output logic [NUM_TAPS-1:0]     oTapMask,
    output logic                    oBusy,
    output logic                    oAddrErr,
    output logic                    oOverrun
);

    seqState_t r_state, w_nextState;

    logic [NUM_BANKS-1:0] w_hostSel;
    logic [LADDR_W-1:0]   w_hostLocal;
    logic                 w_hostOk;
    logic                 w_hostWr;

    logic [IDX_W-1:0]     r_rdCnt;
    logic [BANK_W-1:0]    r_rdBank;
    logic [LADDR_W-1:0]   r_rdLocal;
    logic                 w_rdIssue;

    logic                 r_reqVld;
    logic [IDX_W-1:0]     r_reqIdx;
    logic [BANK_W-1:0]    r_reqBank;
    logic                 r_vld;
    logic [IDX_W-1:0]     r_vldIdx;
    logic [BANK_W-1:0]    r_vldBank;
    logic                 w_loadDone;

    logic [NUM_BANKS-1:0] r_csn, r_wrn;
    logic [LADDR_W-1:0]   r_addr;
    logic [DW-1:0]        r_wrDt;
    logic                 r_addrErr;

    logic                 r_mul, r_add, r_acc, r_ovr;
    logic                 w_run, w_strobeIn, w_pipeBusy, w_strobeOk;
    logic [NUM_TAPS-1:0]  r_mask, w_maskNext;

    fir_bank_addr_map u_hostMap (
        .i_idx       (iAddrRam),
        .o_bankSel   (w_hostSel),
        .o_localAddr (w_hostLocal),
        .o_rangeOk   (w_hostOk)
    );

    assign w_loadDone = r_vld && (r_vldIdx == IDX_W'(NUM_TAPS - 1));

    // The update flag overrides every state, including an unfinished load.
    always_comb begin
        w_nextState = r_state;
        if (iCoeffUpdateFlag) begin
            w_nextState = WRITE;
        end else begin
            case (r_state)
                WRITE:   w_nextState = LOAD;
                LOAD:    w_nextState = w_loadDone ? RUN : LOAD;
                default: w_nextState = r_state;
            endcase
        end
    end

    assign w_hostWr   = (r_state == WRITE) && iCoeffUpdateFlag && !iCsnRam && !iWrnRam;
    assign w_rdIssue  = (w_nextState == LOAD) && (r_rdCnt < IDX_W'(NUM_TAPS));
    assign w_run      = (r_state == RUN) && (w_nextState == RUN);
    assign w_strobeIn = iEnSample_300k && w_run;
    assign w_pipeBusy = r_mul || r_add || r_acc;
    assign w_strobeOk = w_strobeIn && !w_pipeBusy;

    // Counts above NUM_TAPS saturate to a full mask.
    always_comb begin
        w_maskNext = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            w_maskNext[k] = (IDX_W'(k) < iNumOfCoeff);
        end
    end

    always_ff @(posedge iClk_12M) begin
        if (iRsn) begin
            r_state   <= IDLE;
            r_rdCnt   <= '0;
            r_rdBank  <= '0;
            r_rdLocal <= '0;
            r_reqVld  <= 1'b0;
            r_reqIdx  <= '0;
            r_reqBank <= '0;
            r_vld     <= 1'b0;
            r_vldIdx  <= '0;
            r_vldBank <= '0;
            r_csn     <= '1;
            r_wrn     <= '1;
            r_addr    <= '0;
            r_wrDt    <= '0;
            r_addrErr <= 1'b0;
            r_mul     <= 1'b0;
            r_add     <= 1'b0;
            r_acc     <= 1'b0;
            r_ovr     <= 1'b0;
            r_mask    <= '0;
        end else begin
            r_state <= w_nextState;

            if (w_nextState != LOAD) begin
                r_rdCnt   <= '0;
                r_rdBank  <= '0;
                r_rdLocal <= '0;
            end else if (w_rdIssue) begin
                r_rdCnt <= r_rdCnt + IDX_W'(1);
                if (r_rdLocal == LADDR_W'(BANK_DEPTH - 1)) begin
                    r_rdLocal <= '0;
                    r_rdBank  <= r_rdBank + BANK_W'(1);
                end else begin
                    r_rdLocal <= r_rdLocal + LADDR_W'(1);
                end
            end

            r_csn  <= '1;
            r_wrn  <= '1;
            r_addr <= '0;
            r_wrDt <= '0;
            if (w_hostWr && w_hostOk) begin
                r_csn  <= ~w_hostSel;
                r_wrn  <= ~w_hostSel;
                r_addr <= w_hostLocal;
                r_wrDt <= iWrDtRam;
            end else if (w_rdIssue) begin
                r_csn  <= ~(NUM_BANKS'(1) << r_rdBank);
                r_addr <= r_rdLocal;
            end
            r_addrErr <= w_hostWr && !w_hostOk;

            // Read data returns one cycle after the request leaves the block.
            r_reqVld  <= w_rdIssue;
            r_reqIdx  <= r_rdCnt;
            r_reqBank <= r_rdBank;
            r_vld     <= r_reqVld && (w_nextState == LOAD);
            r_vldIdx  <= r_reqIdx;
            r_vldBank <= r_reqBank;

            r_mul <= w_strobeOk;
            r_add <= r_mul && w_run;
            r_acc <= r_add && w_run;
            r_ovr <= w_strobeIn && w_pipeBusy;

            if ((r_state == LOAD) && (w_nextState == RUN)) begin
                r_mask <= w_maskNext;
            end
        end
    end

    assign oCsnRam    = r_csn;
    assign oWrnRam    = r_wrn;
    assign oAddrRam   = r_addr;
    assign oWrDtRam   = r_wrDt;
    assign oCoeffVld  = r_vld;
    assign oCoeffIdx  = r_vld ? r_vldIdx : '0;
    assign oCoeffData = r_vld ? iRdDtRam[r_vldBank*DW +: DW] : '0;
    assign oEnMul     = r_mul;
    assign oEnAdd     = r_add;
    assign oEnAcc     = r_acc;
    assign oTapMask   = r_mask;
    assign oBusy      = (r_state != RUN);
    assign oAddrErr   = r_addrErr;
    assign oOverrun   = r_ovr;

endmodule
`default_nettype wire
